// File: rtl/vga_reg_snapshot.sv
// vga_reg_snapshot: once per video frame, reads a run of CPU registers through a
// spare register-file read port into a shadow buffer. It then publishes the whole
// set on the renderer's register bus in a single cycle, so a frame never shows a
// half-updated register set.
//
// Ports
//   CLK          system clock (same clock as the VGA timing counters)
//   RST          asynchronous active-low reset
//   VS           VGA vertical sync, active low; its falling edge starts a capture
//   freeze       blocks new captures; a capture already running still completes
//   rf_addr      register-file read address (holds its value while rf_rd_en=0)
//   rf_rd_en     read strobe, high while rf_addr is valid
//   rf_data      read data, valid one cycle after its address cycle
//   reg1to5      committed snapshot; register FIRST_REG+k sits in slot k
//   snap_valid   one-cycle pulse in the cycle reg1to5 updates
//   busy         high from the trigger cycle through the commit cycle
//   reg_changed  (only with SNAP_CHANGE_EN) per-slot "value differs from the
//                previous snapshot", updated at each commit
//
// Build option: define SNAP_CHANGE_EN to add the reg_changed output.
module vga_reg_snapshot #(
  parameter int unsigned NUM_REGS  = 5,
  parameter int unsigned FIRST_REG = 1,
  parameter int unsigned REG_W     = 32,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      VS,
  input  logic                      freeze,
  output logic [ADDR_W-1:0]         rf_addr,
  output logic                      rf_rd_en,
  input  logic [REG_W-1:0]          rf_data,
  output logic [NUM_REGS*REG_W-1:0] reg1to5,
  output logic                      snap_valid,
  output logic                      busy
`ifdef SNAP_CHANGE_EN
  ,
  output logic [NUM_REGS-1:0]       reg_changed
`endif
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned BUS_W = NUM_REGS * REG_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_COMMIT
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                vs_q;
  logic [BUS_W-1:0]    shadow_q, shadow_d;
  logic [ADDR_W-1:0]   rf_addr_d;
  logic                rf_rd_en_d;
  logic [BUS_W-1:0]    reg_d;
  logic                snap_valid_d;
  logic                busy_d;
  logic                cap_en;
  logic [IDX_W-1:0]    cap_slot;
  logic                trigger;
`ifdef SNAP_CHANGE_EN
  logic [NUM_REGS-1:0] changed_d;
`endif

  // Falling edge of VS seen while idle and not frozen; edges while busy are dropped.
  assign trigger = vs_q & ~VS & ~freeze & (state_q == S_IDLE);

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      vs_q        <= 1'b1;
      shadow_q    <= '0;
      rf_addr     <= '0;
      rf_rd_en    <= 1'b0;
      reg1to5     <= '0;
      snap_valid  <= 1'b0;
      busy        <= 1'b0;
`ifdef SNAP_CHANGE_EN
      reg_changed <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      vs_q        <= VS;
      shadow_q    <= shadow_d;
      rf_addr     <= rf_addr_d;
      rf_rd_en    <= rf_rd_en_d;
      reg1to5     <= reg_d;
      snap_valid  <= snap_valid_d;
      busy        <= busy_d;
`ifdef SNAP_CHANGE_EN
      reg_changed <= changed_d;
`endif
    end
  end

  // Next-state, read sequencing, shadow capture and commit.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    rf_addr_d    = rf_addr;
    rf_rd_en_d   = 1'b0;
    reg_d        = reg1to5;
    snap_valid_d = 1'b0;
    cap_en       = 1'b0;
    cap_slot     = '0;
`ifdef SNAP_CHANGE_EN
    changed_d    = reg_changed;
`endif

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d    = S_ISSUE;
          idx_d      = '0;
          rf_rd_en_d = 1'b1;
          rf_addr_d  = ADDR_W'(FIRST_REG);
        end
      end
      S_ISSUE: begin
        // Data for the previous address cycle is on rf_data now.
        if (idx_q != '0) begin
          cap_en   = 1'b1;
          cap_slot = idx_q - IDX_W'(1);
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          idx_d      = idx_q + IDX_W'(1);
          rf_rd_en_d = 1'b1;
          // Address wraps modulo 2^ADDR_W.
          rf_addr_d  = ADDR_W'(FIRST_REG + 32'(idx_d));
        end
      end
      S_DRAIN: begin
        cap_en   = 1'b1;
        cap_slot = LAST_IDX;
        state_d  = S_COMMIT;
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (cap_en) begin
      shadow_d[32'(cap_slot) * REG_W +: REG_W] = rf_data;
    end

    // The bus is loaded at the edge that enters COMMIT so the new values and
    // snap_valid are both visible during the COMMIT cycle; shadow_d already
    // includes the final datum captured at that same edge.
    if (state_q == S_DRAIN) begin
      reg_d        = shadow_d;
      snap_valid_d = 1'b1;
`ifdef SNAP_CHANGE_EN
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        changed_d[k] = (shadow_d[k*REG_W +: REG_W] != reg1to5[k*REG_W +: REG_W]);
      end
`endif
    end

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_vga_reg_snapshot.sv
// Bench for vga_reg_snapshot: a default instance (5 registers from index 1) and a
// wrap instance (4 registers from index 30), each fed by a one-cycle-latency
// register-file model over a shared memory image.
module tb_vga_reg_snapshot;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vs, vs2, freeze;
  logic [4:0]   rf_addr, rf_addr2;
  logic         rf_rd_en, rf_rd_en2;
  logic [31:0]  rf_data, rf_data2;
  logic [159:0] reg1to5;
  logic [127:0] reg2;
  logic         snap_valid, snap_valid2, busy, busy2;
`ifdef SNAP_CHANGE_EN
  logic [4:0]   chg;
  logic [3:0]   chg2;
  logic [4:0]   cur_chg;
`endif

  logic [31:0]  mem [32];
  logic [159:0] cur_exp;
  int           n_assert;
  int           n_fail;

  always #5 clk = ~clk;

  vga_reg_snapshot dut (
    .CLK(clk), .RST(rst_n), .VS(vs), .freeze(freeze),
    .rf_addr(rf_addr), .rf_rd_en(rf_rd_en), .rf_data(rf_data),
    .reg1to5(reg1to5), .snap_valid(snap_valid), .busy(busy)
`ifdef SNAP_CHANGE_EN
    , .reg_changed(chg)
`endif
  );

  vga_reg_snapshot #(.NUM_REGS(4), .FIRST_REG(30), .REG_W(32), .ADDR_W(5)) dut2 (
    .CLK(clk), .RST(rst_n), .VS(vs2), .freeze(1'b0),
    .rf_addr(rf_addr2), .rf_rd_en(rf_rd_en2), .rf_data(rf_data2),
    .reg1to5(reg2), .snap_valid(snap_valid2), .busy(busy2)
`ifdef SNAP_CHANGE_EN
    , .reg_changed(chg2)
`endif
  );

  // Register-file read ports: data one cycle after the address, junk when not reading.
  always @(posedge clk) begin
    rf_data  <= rf_rd_en  ? mem[rf_addr]  : 32'hDEAD_BEEF;
    rf_data2 <= rf_rd_en2 ? mem[rf_addr2] : 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected snapshot: slot k holds register (first+k) mod 32.
  function automatic logic [159:0] model_snap(input int first, input int n);
    logic [159:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k*32 +: 32] = mem[(first + k) % 32];
    return r;
  endfunction

  task automatic randomize_mem();
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
  endtask

  // One frame on the default instance, with optional freeze/second-VS disturbances.
  task automatic run_frame(input string tag, input bit frz_edge, input int frz_at,
                           input int glitch_at);
    logic [159:0] exp_new;
    logic [159:0] at5;
    int addrs[$];
    int snap_cnt, snap_at, busy_cnt, n_exp;
    snap_cnt = 0; snap_at = -1; busy_cnt = 0; at5 = '0;
    exp_new = frz_edge ? cur_exp : model_snap(1, 5);
    n_exp   = frz_edge ? 0 : 5;
    @(negedge clk);
    vs = 1'b0;
    freeze = frz_edge;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rf_rd_en) addrs.push_back(int'(rf_addr));
      if (snap_valid) begin snap_cnt++; snap_at = c; end
      if (busy) busy_cnt++;
      if (c == 5) at5 = reg1to5;
      if (c == 0) vs = 1'b1;
      if (frz_edge && c == 1) freeze = 1'b0;
      if (c == frz_at) freeze = 1'b1;
      if (c == glitch_at - 1) vs = 1'b0;
      if (c == glitch_at) vs = 1'b1;
    end
    freeze = 1'b0;
    check($sformatf("%s_nreads", tag), 160'(addrs.size()), 160'(n_exp));
    for (int k = 0; k < n_exp; k++)
      check($sformatf("%s_addr%0d", tag, k), 160'((k < addrs.size()) ? addrs[k] : -1), 160'(1 + k));
    check($sformatf("%s_nsnap", tag), 160'(snap_cnt), 160'(frz_edge ? 0 : 1));
    if (!frz_edge) check($sformatf("%s_snap_at", tag), 160'(snap_at), 160'(6));
    check($sformatf("%s_busy_cycles", tag), 160'(busy_cnt), 160'(frz_edge ? 0 : 7));
    check($sformatf("%s_hold_precommit", tag), at5, cur_exp);
    check($sformatf("%s_bus", tag), reg1to5, exp_new);
`ifdef SNAP_CHANGE_EN
    if (!frz_edge)
      for (int k = 0; k < 5; k++) cur_chg[k] = (exp_new[k*32 +: 32] != cur_exp[k*32 +: 32]);
    check($sformatf("%s_changed", tag), 160'(chg), 160'(cur_chg));
`endif
    cur_exp = exp_new;
  endtask

  initial begin
    logic [159:0] tmp;
    int addrs2[$];
    int snap2_at, quiet_snaps;
    n_assert = 0; n_fail = 0;
    rst_n = 1'b0; vs = 1'b1; vs2 = 1'b1; freeze = 1'b0;
    cur_exp = '0;
`ifdef SNAP_CHANGE_EN
    cur_chg = '0;
`endif
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);

    repeat (3) @(negedge clk);
    check("rst_rd_en", 160'(rf_rd_en), 160'(0));
    check("rst_addr", 160'(rf_addr), 160'(0));
    check("rst_bus", reg1to5, 160'(0));
    check("rst_snap_busy", 160'({snap_valid, busy}), 160'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame with address-tagged data.
    run_frame("f1", 1'b0, -1, -1);
    tmp = reg1to5;
    check("f1_reg1", 160'(tmp[31:0]), 160'(32'h1000_0001));
    check("f1_reg5", 160'(tmp[159:128]), 160'(32'h1000_0005));
    check("f1_addr_hold", 160'(rf_addr), 160'(5));

`ifdef SNAP_CHANGE_EN
    mem[3] = 32'h2000_0003;
    run_frame("chg", 1'b0, -1, -1);
    check("chg_only_reg3", 160'(chg), 160'(5'b00100));
`endif

    randomize_mem();
    run_frame("glitch", 1'b0, -1, 3);
    randomize_mem();
    run_frame("frz_edge", 1'b1, -1, -1);
    randomize_mem();
    run_frame("frz_mid", 1'b0, 2, -1);

    // Reset in the middle of a capture.
    randomize_mem();
    @(negedge clk);
    vs = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) vs = 1'b1;
    end
    check("mid_busy", 160'(busy), 160'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd_en", 160'(rf_rd_en), 160'(0));
    check("mid_rst_addr", 160'(rf_addr), 160'(0));
    check("mid_rst_bus", reg1to5, 160'(0));
    check("mid_rst_snap_busy", 160'({snap_valid, busy}), 160'(0));
    cur_exp = '0;
`ifdef SNAP_CHANGE_EN
    check("mid_rst_changed", 160'(chg), 160'(0));
    cur_chg = '0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    quiet_snaps = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (snap_valid || rf_rd_en) quiet_snaps++;
    end
    check("post_rst_quiet", 160'(quiet_snaps), 160'(0));
    run_frame("post_rst", 1'b0, -1, -1);

    // Random frames with random mid-capture freeze.
    for (int f = 0; f < 3; f++) begin
      randomize_mem();
      run_frame($sformatf("rnd%0d", f), 1'b0, int'($urandom_range(0, 9)) - 2, -1);
    end

    // Wrap instance: registers 30, 31, 0, 1.
    randomize_mem();
    snap2_at = -1;
    @(negedge clk);
    vs2 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rf_rd_en2) addrs2.push_back(int'(rf_addr2));
      if (snap_valid2) snap2_at = c;
      if (c == 0) vs2 = 1'b1;
    end
    check("wrap_nreads", 160'(addrs2.size()), 160'(4));
    for (int k = 0; k < 4; k++)
      check($sformatf("wrap_addr%0d", k), 160'((k < addrs2.size()) ? addrs2[k] : -1),
            160'((30 + k) % 32));
    check("wrap_snap_at", 160'(snap2_at), 160'(5));
    tmp = model_snap(30, 4);
    check("wrap_bus", 160'(reg2), 160'(tmp[127:0]));
    tmp = 160'(reg2);
    check("wrap_slot2_is_reg0", 160'(tmp[95:64]), 160'(mem[0]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
